// File: rtl/lock_ctrl.sv
// Keypad lock sequencer: gathers a CODE_LEN-digit entry, compares it to the
// configured code and drives registered open/close pulses, auto-close and lockout.
module lock_ctrl #(
    parameter int CODE_LEN          = 4,
    parameter int DIGIT_W           = 4,
    parameter int MAX_FAIL          = 3,
    parameter int AUTO_CLOSE_CYCLES = 8,
    parameter int LOCKOUT_CYCLES    = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 key_valid,
    input  logic [DIGIT_W-1:0]                   key_digit,
    input  logic                                 key_clear,
    input  logic                                 close_req,
    input  logic [CODE_LEN*DIGIT_W-1:0]          code,
    output logic                                 open,
    output logic                                 close,
    output logic                                 unlocked,
    output logic                                 locked_out,
    output logic [$clog2(MAX_FAIL+1)-1:0]        fail_cnt
);

    localparam int ENT_W  = CODE_LEN * DIGIT_W;
    localparam int CNT_W  = $clog2(CODE_LEN + 1);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int TMAX   = (AUTO_CLOSE_CYCLES > LOCKOUT_CYCLES) ? AUTO_CLOSE_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W  = $clog2(TMAX + 1);

    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(CODE_LEN - 1);
    localparam logic [TMR_W-1:0] TMR_AUTO   = TMR_W'(AUTO_CLOSE_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LOCK   = TMR_W'(LOCKOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_OPENED,
        S_LOCKOUT
    } state_t;

    state_t              r_state,    w_state;
    logic [ENT_W-1:0]    r_entry,    w_entry;
    logic [CNT_W-1:0]    r_cnt,      w_cnt;
    logic [TMR_W-1:0]    r_timer,    w_timer;
    logic [FAIL_W-1:0]   r_fail,     w_fail;
    logic                r_open,     w_open;
    logic                r_close,    w_close;
    logic                r_unlocked, w_unlocked;
    logic                r_locked,   w_locked;
    logic                r_pend,     w_pend;

    logic [ENT_W+DIGIT_W-1:0] w_ext;
    logic                     w_match;

    // First digit entered ends up in the most significant position.
    assign w_ext   = {r_entry, key_digit};
    assign w_match = (r_entry == code);

    always_comb begin
        w_state    = r_state;
        w_entry    = r_entry;
        w_cnt      = r_cnt;
        w_timer    = r_timer;
        w_fail     = r_fail;
        w_open     = 1'b0;
        w_close    = 1'b0;
        w_unlocked = r_unlocked;
        w_locked   = r_locked;
        w_pend     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (key_clear) begin
                    w_cnt = '0;
                end else if (key_valid) begin
                    w_entry = w_ext[ENT_W-1:0];
                    w_cnt   = r_cnt + 1'b1;
                    if (r_cnt == LAST_DIGIT)
                        w_state = S_CHECK;
                end
            end
            S_CHECK: begin
                w_cnt   = '0;
                w_entry = '0;
                if (w_match) begin
                    w_state    = S_OPENED;
                    w_open     = 1'b1;
                    w_unlocked = 1'b1;
                    w_fail     = '0;
                    w_timer    = TMR_AUTO;
                    // A close request landing on the open edge is served next cycle.
                    w_pend     = close_req;
                end else if (int'(r_fail) + 1 < MAX_FAIL) begin
                    w_fail  = r_fail + 1'b1;
                    w_state = S_IDLE;
                end else begin
                    w_state  = S_LOCKOUT;
                    w_locked = 1'b1;
                    w_fail   = '0;
                    w_timer  = TMR_LOCK;
                end
            end
            S_OPENED: begin
                w_timer = r_timer - 1'b1;
                if (close_req || r_pend || r_timer == TMR_ONE) begin
                    w_close    = 1'b1;
                    w_unlocked = 1'b0;
                    w_timer    = '0;
                    w_state    = S_IDLE;
                end
            end
            S_LOCKOUT: begin
                w_timer = r_timer - 1'b1;
                if (r_timer == TMR_ONE) begin
                    w_locked = 1'b0;
                    w_timer  = '0;
                    w_entry  = '0;
                    w_cnt    = '0;
                    w_state  = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_entry    <= '0;
            r_cnt      <= '0;
            r_timer    <= '0;
            r_fail     <= '0;
            r_open     <= 1'b0;
            r_close    <= 1'b0;
            r_unlocked <= 1'b0;
            r_locked   <= 1'b0;
            r_pend     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_entry    <= w_entry;
            r_cnt      <= w_cnt;
            r_timer    <= w_timer;
            r_fail     <= w_fail;
            r_open     <= w_open;
            r_close    <= w_close;
            r_unlocked <= w_unlocked;
            r_locked   <= w_locked;
            r_pend     <= w_pend;
        end
    end

    assign open       = r_open;
    assign close      = r_close;
    assign unlocked   = r_unlocked;
    assign locked_out = r_locked;
    assign fail_cnt   = r_fail;

endmodule

// File: tb/tb_lock_ctrl.sv
// Directed bench for lock_ctrl: entry, auto/early close, lockout, clear and async reset.
module tb_lock_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid, key_clear, close_req;
    logic [3:0]  key_digit;
    logic [15:0] code;
    logic        open, close, unlocked, locked_out;
    logic [1:0]  fail_cnt;

    int checks   = 0;
    int failures = 0;

    lock_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .key_clear  (key_clear),
        .close_req  (close_req),
        .code       (code),
        .open       (open),
        .close      (close),
        .unlocked   (unlocked),
        .locked_out (locked_out),
        .fail_cnt   (fail_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // open must never coincide with close or lockout
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            checks++;
            assert (!(open && close) && !(open && locked_out)) else begin
                failures++;
                $error("FAIL excl open=%0b close=%0b locked_out=%0b", open, close, locked_out);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic o, input logic c, input logic u,
                           input logic l, input logic [1:0] f);
        chk({tag, ".open"}, 32'(open), 32'(o));
        chk({tag, ".close"}, 32'(close), 32'(c));
        chk({tag, ".unlocked"}, 32'(unlocked), 32'(u));
        chk({tag, ".locked_out"}, 32'(locked_out), 32'(l));
        chk({tag, ".fail_cnt"}, 32'(fail_cnt), 32'(f));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        tick();
        key_valid = 1'b0;
    endtask

    // Four digits then the CHECK cycle; returns in the cycle after CHECK.
    task automatic enter(input logic [15:0] c, input logic creq);
        for (int i = 0; i < 4; i++) press(c[15-4*i -: 4]);
        close_req = creq;
        tick();
        close_req = 1'b0;
    endtask

    task automatic req_close();
        close_req = 1'b1;
        tick();
        close_req = 1'b0;
    endtask

    initial begin
        rst = 1'b0; key_valid = 1'b0; key_clear = 1'b0; close_req = 1'b0;
        key_digit = 4'h0; code = 16'h1234;
        #3;
        chk_all("reset", 0, 0, 0, 0, 2'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // correct entry with auto-close
        enter(16'h1234, 1'b0);
        chk_all("open_T2", 1, 0, 1, 0, 2'd0);
        for (int k = 3; k <= 9; k++) begin
            tick();
            chk_all($sformatf("opened_T%0d", k), 0, 0, 1, 0, 2'd0);
        end
        tick();
        chk_all("auto_close_T10", 0, 1, 0, 0, 2'd0);
        tick();
        chk_all("after_close_T11", 0, 0, 0, 0, 2'd0);

        // early close 3 cycles after open
        enter(16'h1234, 1'b0);
        chk("early.open", 32'(open), 32'd1);
        tick(); tick(); tick();
        chk("early.still_unlocked", 32'(unlocked), 32'd1);
        req_close();
        chk_all("early_close", 0, 1, 0, 0, 2'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("early.no_second_close", 32'(close), 32'd0);
        end

        // close_req on the same edge that produces open
        enter(16'h1234, 1'b1);
        chk_all("pend_open", 1, 0, 1, 0, 2'd0);
        tick();
        chk_all("pend_close", 0, 1, 0, 0, 2'd0);
        tick();

        // lockout after three mismatches
        enter(16'h1111, 1'b0);
        chk_all("miss1", 0, 0, 0, 0, 2'd1);
        enter(16'h1111, 1'b0);
        chk_all("miss2", 0, 0, 0, 0, 2'd2);
        enter(16'h1111, 1'b0);
        chk_all("lockout_T2", 0, 0, 0, 1, 2'd0);
        enter(16'h1234, 1'b0);
        chk_all("lockout_ignores_entry", 0, 0, 0, 1, 2'd0);
        for (int k = 8; k <= 17; k++) begin
            tick();
            chk($sformatf("lockout_T%0d", k), 32'(locked_out), 32'd1);
        end
        tick();
        chk_all("lockout_end_T18", 0, 0, 0, 0, 2'd0);
        enter(16'h1234, 1'b0);
        chk_all("post_lockout_open", 1, 0, 1, 0, 2'd0);
        req_close();
        chk("post_lockout_close", 32'(close), 32'd1);
        tick();

        // key_clear beats a simultaneous digit; digit order matters
        press(4'h1);
        press(4'h2);
        key_clear = 1'b1;
        press(4'h9);
        key_clear = 1'b0;
        enter(16'h1234, 1'b0);
        chk_all("clear_then_open", 1, 0, 1, 0, 2'd0);
        req_close();
        tick();
        enter(16'h4321, 1'b0);
        chk_all("reversed_miss", 0, 0, 0, 0, 2'd1);

        // success clears the failure count
        enter(16'h5555, 1'b0);
        chk("two_miss.fail", 32'(fail_cnt), 32'd2);
        enter(16'h1234, 1'b0);
        chk_all("success_resets_fail", 1, 0, 1, 0, 2'd0);
        req_close();
        tick();
        enter(16'h1111, 1'b0);
        chk_all("fresh_miss", 0, 0, 0, 0, 2'd1);

        // async reset mid-OPENED
        enter(16'h1234, 1'b0);
        tick(); tick();
        chk("pre_rst.unlocked", 32'(unlocked), 32'd1);
        #2 rst = 1'b0;
        #1 chk_all("rst_mid_opened", 0, 0, 0, 0, 2'd0);
        #1 rst = 1'b1;
        tick();

        // async reset mid-LOCKOUT
        enter(16'h1111, 1'b0);
        enter(16'h1111, 1'b0);
        enter(16'h1111, 1'b0);
        tick(); tick(); tick();
        chk("pre_rst.locked_out", 32'(locked_out), 32'd1);
        #2 rst = 1'b0;
        #1 chk_all("rst_mid_lockout", 0, 0, 0, 0, 2'd0);
        #1 rst = 1'b1;
        tick();
        enter(16'h1234, 1'b0);
        chk_all("open_after_rst", 1, 0, 1, 0, 2'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
